// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: access widths, FSM states,
// and the lane/byte-enable decoder used by both store steering and error flagging.
package mem_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] be;
    logic       misalign;
  } lane_ctl_t;

  // A misaligned or reserved-width access yields no byte enables at all.
  function automatic lane_ctl_t lane_ctl(input logic [1:0] width, input logic [1:0] lane);
    lane_ctl_t c;
    c.be       = 4'b0000;
    c.misalign = 1'b0;
    case (width)
      MEM_B: c.be = 4'b0001 << lane;
      MEM_H: begin
        c.misalign = lane[0];
        c.be       = lane[1] ? 4'b1100 : 4'b0011;
      end
      MEM_W: begin
        c.misalign = (lane != 2'b00);
        c.be       = 4'b1111;
      end
      default: c.misalign = 1'b1;
    endcase
    if (c.misalign) c.be = 4'b0000;
    return c;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request bus between the memory pipeline stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        write;
  logic [31:0] data_out;
  logic        extend;
  logic [1:0]  width;
  logic        ack;
  logic [31:0] data_in;
  logic        err;

  modport master (
    output req, addr, write, data_out, extend, width,
    input  ack, data_in, err
  );

  modport slave (
    input  req, addr, write, data_out, extend, width,
    output ack, data_in, err
  );
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one access at a time, LATENCY cycles from acceptance
// to a single-cycle ack, with lane steering and sign/zero extension for loads.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  dmem_responder_if.slave  bus
);

  state_t                  state;
  logic [3:0]              cnt;
  logic [31:0]             data_in_r;

  logic [ADDR_WIDTH+1:0]   addr_p0;
  logic [31:0]             wdata_p0;
  logic                    write_p0;
  logic                    extend_p0;
  logic [1:0]              width_p0;

  lane_ctl_t               ctl;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [3:0]              ram_we;
  logic [31:0]             ram_rdata;
  logic                    unused_addr_hi;

  function automatic logic [31:0] replicate(input logic [1:0] w, input logic [31:0] d);
    case (w)
      MEM_B:   return {4{d[7:0]}};
      MEM_H:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend_lane(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] w, input logic sx);
    logic signed [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (w)
      MEM_B:   return {{24{sx & sh[7]}}, sh[7:0]};
      MEM_H:   return {{16{sx & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH+2];
  assign ctl            = lane_ctl(width_p0, addr_p0[1:0]);

  // The RAM must be read one cycle before RESP; with LATENCY=1 that is the
  // accepting IDLE cycle, before the request fields have been latched.
  assign ram_addr = (state == ST_IDLE) ? bus.addr[ADDR_WIDTH+1:2] : addr_p0[ADDR_WIDTH+1:2];
  assign ram_we   = (state == ST_RESP && bus.req && write_p0) ? ctl.be : 4'b0000;

  assign bus.ack     = (state == ST_RESP) && bus.req;
  assign bus.err     = bus.ack && ctl.misalign;
  assign bus.data_in = data_in_r;

  dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (replicate(width_p0, wdata_p0)),
    .rdata (ram_rdata)
  );

  // p0: request fields captured at acceptance
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.req) begin
      addr_p0   <= bus.addr[ADDR_WIDTH+1:0];
      wdata_p0  <= bus.data_out;
      write_p0  <= bus.write;
      extend_p0 <= bus.extend;
      width_p0  <= bus.width;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      data_in_r <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            cnt   <= 4'(LATENCY - 1);
            state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!bus.req)          state <= ST_IDLE;
          else if (cnt == 4'd1)  state <= ST_RESP;
          else                   cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          if (bus.req && !write_p0) begin
            data_in_r <= ctl.misalign ? 32'd0
                                      : extend_lane(ram_rdata, addr_p0[1:0], width_p0, extend_p0);
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance at LATENCY=1, one at LATENCY=3.
module tb_dmem_responder;
  import mem_pkg::*;

  typedef struct packed {
    logic        err;
    logic        ld;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  dmem_responder_if ifa ();
  dmem_responder_if ifb ();

  dmem_responder #(.ADDR_WIDTH(12), .LATENCY(1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  dmem_responder #(.ADDR_WIDTH(12), .LATENCY(3)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_bus(input int sel, input logic rq, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic ext, input logic [1:0] w);
    if (sel == 1) begin
      ifb.req = rq; ifb.write = wr; ifb.addr = a; ifb.data_out = d; ifb.extend = ext; ifb.width = w;
    end else begin
      ifa.req = rq; ifa.write = wr; ifa.addr = a; ifa.data_out = d; ifa.extend = ext; ifa.width = w;
    end
  endtask

  task automatic drop_req(input int sel);
    if (sel == 1) ifb.req = 1'b0;
    else          ifa.req = 1'b0;
  endtask

  task automatic acc(input int sel, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic ext, input logic [1:0] w, input logic exp_err,
                     input logic [31:0] exp_data);
    exp_t e;
    int   lat;
    int   got;
    logic ak;
    lat    = (sel == 1) ? 3 : 1;
    e.err  = exp_err;
    e.ld   = !wr;
    e.data = exp_data;
    @(negedge clk);
    if (sel == 1) qb.push_back(e);
    else          qa.push_back(e);
    set_bus(sel, 1'b1, wr, a, d, ext, w);
    got = 0;
    for (int k = 1; k <= lat + 2 && got == 0; k++) begin
      @(posedge clk); #1;
      ak = (sel == 1) ? ifb.ack : ifa.ack;
      if (ak) got = k;
    end
    if (got != 0) begin
      @(posedge clk); #1;
    end
    drop_req(sel);
    chk((sel == 1) ? "b_ack_latency" : "a_ack_latency", got, lat);
  endtask

  // Monitors: pop on every ack, check err immediately and load data one cycle later.
  initial begin
    exp_t        e;
    logic        pend;
    logic [31:0] pexp;
    pend = 1'b0;
    pexp = 32'd0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("a_data_in", ifa.data_in, pexp);
        pend = 1'b0;
      end
      if (ifa.ack) begin
        if (qa.size() == 0) chk("a_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = qa.pop_front();
          chk("a_err", {31'd0, ifa.err}, {31'd0, e.err});
          if (e.ld) begin pend = 1'b1; pexp = e.data; end
        end
      end
    end
  end

  initial begin
    exp_t        e;
    logic        pend;
    logic [31:0] pexp;
    pend = 1'b0;
    pexp = 32'd0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("b_data_in", ifb.data_in, pexp);
        pend = 1'b0;
      end
      if (ifb.ack) begin
        if (qb.size() == 0) chk("b_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = qb.pop_front();
          chk("b_err", {31'd0, ifb.err}, {31'd0, e.err});
          if (e.ld) begin pend = 1'b1; pexp = e.data; end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int a1;
    int a2;
    int n_ack;
    set_bus(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    set_bus(1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    chk("rst_a_ack", {31'd0, ifa.ack}, 32'd0);
    chk("rst_a_err", {31'd0, ifa.err}, 32'd0);
    chk("rst_a_data_in", ifa.data_in, 32'd0);
    chk("rst_b_data_in", ifb.data_in, 32'd0);
    reset_n = 1'b1;

    // LATENCY=1: word round trip, byte/half lanes, misalignment, aliasing
    acc(0, 1'b1, 32'h40,  32'hDEADBEEF, 1'b0, MEM_W, 1'b0, 32'h0);
    acc(0, 1'b0, 32'h40,  32'h0,        1'b0, MEM_W, 1'b0, 32'hDEADBEEF);
    acc(0, 1'b1, 32'h100, 32'h11223344, 1'b0, MEM_W, 1'b0, 32'h0);
    acc(0, 1'b1, 32'h101, 32'h000000AB, 1'b0, MEM_B, 1'b0, 32'h0);
    acc(0, 1'b0, 32'h101, 32'h0,        1'b1, MEM_B, 1'b0, 32'hFFFFFFAB);
    acc(0, 1'b0, 32'h101, 32'h0,        1'b0, MEM_B, 1'b0, 32'h000000AB);
    acc(0, 1'b0, 32'h100, 32'h0,        1'b0, MEM_W, 1'b0, 32'h1122AB44);
    acc(0, 1'b1, 32'h102, 32'h00008765, 1'b0, MEM_H, 1'b0, 32'h0);
    acc(0, 1'b0, 32'h102, 32'h0,        1'b1, MEM_H, 1'b0, 32'hFFFF8765);
    acc(0, 1'b0, 32'h100, 32'h0,        1'b0, MEM_H, 1'b0, 32'h0000AB44);
    acc(0, 1'b1, 32'h103, 32'h00001234, 1'b0, MEM_H, 1'b1, 32'h0);
    acc(0, 1'b0, 32'h100, 32'h0,        1'b0, MEM_W, 1'b0, 32'h8765AB44);
    acc(0, 1'b0, 32'h100, 32'h0,        1'b0, 2'd3,  1'b1, 32'h0);
    acc(0, 1'b0, 32'h100, 32'h0,        1'b0, MEM_W, 1'b0, 32'h8765AB44);
    acc(0, 1'b0, 32'h102, 32'h0,        1'b0, MEM_W, 1'b1, 32'h0);
    acc(0, 1'b0, 32'h4040, 32'h0,       1'b0, MEM_W, 1'b0, 32'hDEADBEEF);

    // LATENCY=3: single access, then a held request yielding two acks
    acc(1, 1'b1, 32'h200, 32'hCAFEF00D, 1'b0, MEM_W, 1'b0, 32'h0);
    acc(1, 1'b0, 32'h200, 32'h0,        1'b0, MEM_W, 1'b0, 32'hCAFEF00D);
    @(negedge clk);
    qb.push_back('{err: 1'b0, ld: 1'b1, data: 32'hCAFEF00D});
    qb.push_back('{err: 1'b0, ld: 1'b1, data: 32'hCAFEF00D});
    set_bus(1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, MEM_W);
    a1 = 0;
    a2 = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (ifb.ack) begin
        if (a1 == 0)      a1 = k;
        else if (a2 == 0) a2 = k;
      end
    end
    @(posedge clk); #1;
    drop_req(1);
    chk("b2b_first_ack", a1, 3);
    chk("b2b_second_ack", a2, 7);

    // Abandon a store in WAIT
    @(negedge clk);
    set_bus(1, 1'b1, 1'b1, 32'h200, 32'h55555555, 1'b0, MEM_W);
    n_ack = 0;
    @(posedge clk); #1;
    if (ifb.ack) n_ack++;
    @(posedge clk); #1;
    drop_req(1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ifb.ack) n_ack++;
    end
    chk("abandon_no_ack", n_ack, 0);
    chk("abandon_data_in_held", ifb.data_in, 32'hCAFEF00D);
    acc(1, 1'b0, 32'h200, 32'h0, 1'b0, MEM_W, 1'b0, 32'hCAFEF00D);

    // Asynchronous reset in the middle of WAIT
    acc(0, 1'b0, 32'h40, 32'h0, 1'b0, MEM_W, 1'b0, 32'hDEADBEEF);
    @(negedge clk);
    set_bus(1, 1'b1, 1'b1, 32'h200, 32'h12345678, 1'b0, MEM_W);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_b_ack", {31'd0, ifb.ack}, 32'd0);
    chk("midrst_b_err", {31'd0, ifb.err}, 32'd0);
    chk("midrst_b_data_in", ifb.data_in, 32'd0);
    chk("midrst_a_data_in", ifa.data_in, 32'd0);
    drop_req(1);
    @(negedge clk);
    reset_n = 1'b1;
    acc(1, 1'b0, 32'h200,  32'h0, 1'b0, MEM_W, 1'b0, 32'hCAFEF00D);
    acc(0, 1'b0, 32'h4040, 32'h0, 1'b0, MEM_W, 1'b0, 32'hDEADBEEF);

    repeat (3) @(negedge clk);
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the load/store request interface driven by the memory pipeline stage. It accepts one request at a time and performs the access against an internal byte-writable word RAM after a programmable number of wait cycles. It completes each access with a single-cycle `ack` and, for loads, returns a lane-selected, sign- or zero-extended result on `data_in` that holds until the next completed load. It sits between the memory stage and on-chip data RAM, and is the sole driver of `ack` and `data_in`.

## Interface
- `ADDR_WIDTH`, 12: word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words (16 KiB at default).
- `LATENCY`, 1: cycles from acceptance to `ack`; legal range 1..15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in 1: access request; held until `ack` or abandoned.
- `addr` in 32: byte address; bits above `ADDR_WIDTH+1` are ignored (aliasing).
- `write` in 1: 1 = store, 0 = load.
- `data_out` in 32: store data, right-justified.
- `extend` in 1: on loads, 1 = sign-extend, 0 = zero-extend.
- `width` in 2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `ack` out 1: one-cycle completion pulse.
- `data_in` out 32: registered load result.
- `err` out 1: pulses with `ack` for a misaligned access or `width` = 3.

## Operation
- FSM states:
  - IDLE:
    - If `req` is high, latch `addr`, `write`, `data_out`, `extend` and `width`, and load the wait counter with `LATENCY-1`.
    - Next state is RESP if `LATENCY` = 1, otherwise WAIT.
  - WAIT:
    - If `req` is low, abandon the access and return to IDLE.
    - If the counter is 1, go to RESP; otherwise decrement the counter.
  - RESP:
    - `ack` = `req`.
    - If `req` is low, abandon the access: no `ack`, no write, no `data_in` update.
    - Always return to IDLE.
- Each request accepted in IDLE is a new access, including one still held after `ack` because of a downstream stall. Repeating a load or store is harmless.
- Alignment: a half access requires `addr[0]` = 0; a word access requires `addr[1:0]` = 0. A violating access, or `width` = 3:
  - completes normally with `ack` = 1 and `err` = 1;
  - performs no RAM write;
  - sets `data_in` to 0 if it is a load.
- Store: byte enables come from the lane `addr[1:0]` and `width`; `data_out` is replicated onto the selected lanes (byte to all four, half to both halves). The write commits at the edge ending the RESP cycle with `ack` = 1.
- Load:
  - The RAM word is read in the cycle before RESP.
  - The addressed lane is shifted down, then extended per `extend` (sign from bit 7 for byte, bit 15 for half).
  - The result is registered into `data_in` at the edge ending the ack cycle.
  - `data_in` holds through stores, idle cycles and abandoned accesses.
- Reset, asynchronous and effective mid-operation: state = IDLE, `ack` = 0, `err` = 0, `data_in` = 0, counter = 0. An in-flight access is dropped and a pending store does not commit. RAM contents are not cleared.

## Timing
- Request accepted at cycle 0; `ack` and `err` are high during cycle `LATENCY` only.
- Load data is valid on `data_in` from cycle `LATENCY+1` onward.
- IDLE is always visited after RESP, so the earliest next acceptance is cycle `LATENCY+1`. Throughput is one access per `LATENCY+1` cycles.
- `ack` and `err` are combinational from state and `req`; `data_in` is a pure register output.
- Requester-side inputs must be stable from acceptance through the ack cycle. Only the latched copies are used.

## Structure
- Shared package `mem_pkg`: width encodings `MEM_B`/`MEM_H`/`MEM_W`, FSM state enum, and a helper that computes byte enables and the misaligned flag from (`width`, `addr[1:0]`).
- One sub-module `dmem_ram`: synchronous single-port 2^ADDR_WIDTH×32 RAM with a 4-bit byte write enable and a registered read.
- FSM, counter, lane steering and extension live in `dmem_responder`.

## Test plan
- Word round trip, `LATENCY`=1: store 0xDEADBEEF to 0x40 (`ack` at cycle 1), then load 0x40 → `data_in` = 0xDEADBEEF at cycle 2 of the load; `err` = 0.
- Byte lanes: store byte 0xAB to 0x101; load byte 0x101 with `extend`=1 → 0xFFFFFFAB, with `extend`=0 → 0x000000AB; word at 0x100 changes only in bits [15:8].
- Misalign: half store 0x1234 to 0x103 → `ack` = `err` = 1, word at 0x100 unchanged; word load from 0x102 → `data_in` = 0, `err` = 1.
- `LATENCY`=3: request at cycle 0 → `ack` only at cycle 3; a back-to-back held `req` yields the second `ack` at cycle 7.
- Abandon: `LATENCY`=3 store, drop `req` at cycle 2 → no `ack`, RAM unchanged, FSM in IDLE at cycle 3, `data_in` still shows the prior load value.
- Reset mid-WAIT: assert `reset_n` low asynchronously between edges → `ack`, `err` and `data_in` read 0 immediately; pending store not committed; after release a new load completes normally.
